// File: rtl/core_sequencer_if.sv
// ============================================================================
//  core_sequencer_if
//  Handshake and control bundle between the instruction sequencer and the
//  datapath / memory port.
//  Rev 1.0 - initial release
// ============================================================================
`default_nettype none

interface core_sequencer_if;
    logic [6:0] opcode;
    logic       mem_ready;
    logic       branch_taken;
    logic       mem_req;
    logic       mem_we;
    logic       addr_sel;
    logic       ir_load;
    logic       pc_en;
    logic [1:0] pc_sel;
    logic       reg_we;
    logic [1:0] wb_sel;
    logic       instr_retired;
    logic       trap;
    logic [2:0] state;

    modport master (
        input  opcode, mem_ready, branch_taken,
        output mem_req, mem_we, addr_sel, ir_load, pc_en, pc_sel,
               reg_we, wb_sel, instr_retired, trap, state
    );

    modport slave (
        output opcode, mem_ready, branch_taken,
        input  mem_req, mem_we, addr_sel, ir_load, pc_en, pc_sel,
               reg_we, wb_sel, instr_retired, trap, state
    );
endinterface

`default_nettype wire

// File: rtl/core_sequencer.sv
// ============================================================================
//  core_sequencer
//  Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the RV32I core with a
//  sticky TRAP on bus timeout or illegal opcode.
//  Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module core_sequencer #(
    parameter int TIMEOUT = 16
) (
    input  wire logic        clk,
    input  wire logic        reset,
    core_sequencer_if.master bus
);

    // Width of 1 keeps the counter legal when the timeout is disabled.
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] C_WAIT_LIMIT = CW'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

    localparam logic [6:0] C_OP_R      = 7'b0110011;
    localparam logic [6:0] C_OP_IALU   = 7'b0010011;
    localparam logic [6:0] C_OP_LOAD   = 7'b0000011;
    localparam logic [6:0] C_OP_STORE  = 7'b0100011;
    localparam logic [6:0] C_OP_BRANCH = 7'b1100011;
    localparam logic [6:0] C_OP_JAL    = 7'b1101111;
    localparam logic [6:0] C_OP_JALR   = 7'b1100111;
    localparam logic [6:0] C_OP_LUI    = 7'b0110111;
    localparam logic [6:0] C_OP_AUIPC  = 7'b0010111;

    localparam logic [3:0] C_CLS_R       = 4'd0;
    localparam logic [3:0] C_CLS_IALU    = 4'd1;
    localparam logic [3:0] C_CLS_LOAD    = 4'd2;
    localparam logic [3:0] C_CLS_STORE   = 4'd3;
    localparam logic [3:0] C_CLS_BRANCH  = 4'd4;
    localparam logic [3:0] C_CLS_JAL     = 4'd5;
    localparam logic [3:0] C_CLS_JALR    = 4'd6;
    localparam logic [3:0] C_CLS_LUI     = 4'd7;
    localparam logic [3:0] C_CLS_AUIPC   = 4'd8;
    localparam logic [3:0] C_CLS_ILLEGAL = 4'd9;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic [3:0]    r_cls;
    logic [3:0]    w_cls;
    logic [CW-1:0] r_wait;
    logic          w_mem_phase;
    logic          w_timeout;

    logic       w_mem_req;
    logic       w_mem_we;
    logic       w_addr_sel;
    logic       w_ir_load;
    logic       w_pc_en;
    logic [1:0] w_pc_sel;
    logic       w_reg_we;
    logic [1:0] w_wb_sel;
    logic       w_retired;
    logic       w_trap;

    always_comb begin
        case (bus.opcode)
            C_OP_R:      w_cls = C_CLS_R;
            C_OP_IALU:   w_cls = C_CLS_IALU;
            C_OP_LOAD:   w_cls = C_CLS_LOAD;
            C_OP_STORE:  w_cls = C_CLS_STORE;
            C_OP_BRANCH: w_cls = C_CLS_BRANCH;
            C_OP_JAL:    w_cls = C_CLS_JAL;
            C_OP_JALR:   w_cls = C_CLS_JALR;
            C_OP_LUI:    w_cls = C_CLS_LUI;
            C_OP_AUIPC:  w_cls = C_CLS_AUIPC;
            default:     w_cls = C_CLS_ILLEGAL;
        endcase
    end

    assign w_mem_phase = (r_state == S_FETCH) || (r_state == S_MEM);
    assign w_timeout   = (TIMEOUT > 0) && w_mem_phase && !bus.mem_ready &&
                         (r_wait == C_WAIT_LIMIT);

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_FETCH: begin
                if (bus.mem_ready)  w_next = S_DECODE;
                else if (w_timeout) w_next = S_TRAP;
            end
            S_DECODE: begin
                w_next = (w_cls == C_CLS_ILLEGAL) ? S_TRAP : S_EXEC;
            end
            S_EXEC: begin
                if ((r_cls == C_CLS_LOAD) || (r_cls == C_CLS_STORE)) w_next = S_MEM;
                else if (r_cls == C_CLS_BRANCH)                      w_next = S_FETCH;
                else                                                 w_next = S_WB;
            end
            S_MEM: begin
                if (bus.mem_ready)  w_next = (r_cls == C_CLS_STORE) ? S_FETCH : S_WB;
                else if (w_timeout) w_next = S_TRAP;
            end
            S_WB:    w_next = S_FETCH;
            S_TRAP:  w_next = S_TRAP;
            default: w_next = S_TRAP;
        endcase
    end

    // The wait counter is zero whenever a FETCH or MEM phase begins, since
    // every state that can precede one leaves it cleared.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_FETCH;
            r_cls   <= C_CLS_R;
            r_wait  <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == S_DECODE) begin
                r_cls <= w_cls;
            end
            if (w_mem_phase && !bus.mem_ready && !w_timeout) begin
                r_wait <= r_wait + CW'(1);
            end else begin
                r_wait <= '0;
            end
        end
    end

    always_comb begin
        w_mem_req  = 1'b0;
        w_mem_we   = 1'b0;
        w_addr_sel = 1'b0;
        w_ir_load  = 1'b0;
        w_pc_en    = 1'b0;
        w_pc_sel   = 2'b00;
        w_reg_we   = 1'b0;
        w_wb_sel   = 2'b00;
        w_retired  = 1'b0;
        w_trap     = 1'b0;
        case (r_state)
            S_FETCH: begin
                w_mem_req = 1'b1;
                w_ir_load = bus.mem_ready;
            end
            S_EXEC: begin
                if (r_cls == C_CLS_BRANCH) begin
                    w_pc_en   = 1'b1;
                    w_pc_sel  = bus.branch_taken ? 2'b01 : 2'b00;
                    w_retired = 1'b1;
                end
            end
            S_MEM: begin
                w_mem_req  = 1'b1;
                w_addr_sel = 1'b1;
                w_mem_we   = (r_cls == C_CLS_STORE);
                if (bus.mem_ready && (r_cls == C_CLS_STORE)) begin
                    w_pc_en   = 1'b1;
                    w_retired = 1'b1;
                end
            end
            S_WB: begin
                w_reg_we  = 1'b1;
                w_pc_en   = 1'b1;
                w_retired = 1'b1;
                case (r_cls)
                    C_CLS_LOAD: w_wb_sel = 2'b01;
                    C_CLS_JAL: begin
                        w_wb_sel = 2'b10;
                        w_pc_sel = 2'b10;
                    end
                    C_CLS_JALR: begin
                        w_wb_sel = 2'b10;
                        w_pc_sel = 2'b11;
                    end
                    C_CLS_LUI:  w_wb_sel = 2'b11;
                    default:    w_wb_sel = 2'b00;
                endcase
            end
            S_TRAP:  w_trap = 1'b1;
            default: ;
        endcase
    end

    // Reset is asynchronous, so outputs are masked combinationally rather
    // than waiting for the state register to settle.
    assign bus.mem_req       = w_mem_req  & ~reset;
    assign bus.mem_we        = w_mem_we   & ~reset;
    assign bus.addr_sel      = w_addr_sel & ~reset;
    assign bus.ir_load       = w_ir_load  & ~reset;
    assign bus.pc_en         = w_pc_en    & ~reset;
    assign bus.pc_sel        = reset ? 2'b00 : w_pc_sel;
    assign bus.reg_we        = w_reg_we   & ~reset;
    assign bus.wb_sel        = reset ? 2'b00 : w_wb_sel;
    assign bus.instr_retired = w_retired  & ~reset;
    assign bus.trap          = w_trap     & ~reset;
    assign bus.state         = reset ? 3'd0 : r_state;

endmodule

`default_nettype wire

// File: tb/tb_core_sequencer.sv
// ============================================================================
//  tb_core_sequencer
//  Directed cycle-by-cycle check of the sequencer output vector.
//  Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_core_sequencer;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IALU   = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_BAD    = 7'b1111111;

    logic clk;
    logic reset;
    int   err_cnt;
    int   chk_cnt;

    core_sequencer_if sif ();

    core_sequencer #(.TIMEOUT(4)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (sif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    // {state, mem_req, mem_we, addr_sel, ir_load, pc_en, pc_sel, reg_we, wb_sel, retired, trap}
    function automatic logic [14:0] ev(input logic [2:0] st, input logic req, input logic we,
                                       input logic asel, input logic irl, input logic pce,
                                       input logic [1:0] pcs, input logic rwe, input logic [1:0] wbs,
                                       input logic ret, input logic trp);
        return {st, req, we, asel, irl, pce, pcs, rwe, wbs, ret, trp};
    endfunction

    function automatic logic [14:0] obs();
        return {sif.state, sif.mem_req, sif.mem_we, sif.addr_sel, sif.ir_load, sif.pc_en,
                sif.pc_sel, sif.reg_we, sif.wb_sel, sif.instr_retired, sif.trap};
    endfunction

    function automatic logic [14:0] e_wb(input logic [1:0] wbs, input logic [1:0] pcs);
        return ev(3'd4, 0, 0, 0, 0, 1, pcs, 1, wbs, 1, 0);
    endfunction

    function automatic logic [14:0] e_br(input logic [1:0] pcs);
        return ev(3'd2, 0, 0, 0, 0, 1, pcs, 0, 2'b00, 1, 0);
    endfunction

    task automatic check_val(input string tag, input logic [14:0] got, input logic [14:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got=%b exp=%b", tag, got, exp);
        end
    endtask

    // Called at a falling edge: apply inputs, check outputs, advance one cycle.
    task automatic step(input string tag, input logic [6:0] opc, input logic rdy,
                        input logic bt, input logic [14:0] exp);
        sif.opcode       = opc;
        sif.mem_ready    = rdy;
        sif.branch_taken = bt;
        #1;
        check_val(tag, obs(), exp);
        @(negedge clk);
    endtask

    logic [14:0] E_ZERO, E_F_RDY, E_F_WAIT, E_DEC, E_EXEC, E_MEM_LD, E_ST_RET, E_ST_WAIT, E_TRAP;

    initial begin
        err_cnt   = 0;
        chk_cnt   = 0;
        E_ZERO    = '0;
        E_F_RDY   = ev(3'd0, 1, 0, 0, 1, 0, 2'b00, 0, 2'b00, 0, 0);
        E_F_WAIT  = ev(3'd0, 1, 0, 0, 0, 0, 2'b00, 0, 2'b00, 0, 0);
        E_DEC     = ev(3'd1, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 0, 0);
        E_EXEC    = ev(3'd2, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 0, 0);
        E_MEM_LD  = ev(3'd3, 1, 0, 1, 0, 0, 2'b00, 0, 2'b00, 0, 0);
        E_ST_RET  = ev(3'd3, 1, 1, 1, 0, 1, 2'b00, 0, 2'b00, 1, 0);
        E_ST_WAIT = ev(3'd3, 1, 1, 1, 0, 0, 2'b00, 0, 2'b00, 0, 0);
        E_TRAP    = ev(3'd5, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 0, 1);

        reset            = 1'b1;
        sif.opcode       = OP_R;
        sif.mem_ready    = 1'b1;
        sif.branch_taken = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_val("reset_outputs", obs(), E_ZERO);
        reset = 1'b0;

        // R then IALU back to back: 4-cycle period
        step("r_fetch",  OP_R, 1, 0, E_F_RDY);
        step("r_decode", OP_R, 1, 0, E_DEC);
        step("r_exec",   OP_R, 1, 0, E_EXEC);
        step("r_wb",     OP_R, 1, 0, e_wb(2'b00, 2'b00));
        step("i_fetch",  OP_IALU, 1, 0, E_F_RDY);
        step("i_decode", OP_IALU, 1, 0, E_DEC);
        step("i_exec",   OP_IALU, 1, 0, E_EXEC);
        step("i_wb",     OP_IALU, 1, 0, e_wb(2'b00, 2'b00));

        // LOAD with two memory wait cycles
        step("ld_fetch", OP_LOAD, 1, 0, E_F_RDY);
        step("ld_dec",   OP_LOAD, 1, 0, E_DEC);
        step("ld_exec",  OP_LOAD, 1, 0, E_EXEC);
        step("ld_mem0",  OP_LOAD, 0, 0, E_MEM_LD);
        step("ld_mem1",  OP_LOAD, 0, 0, E_MEM_LD);
        step("ld_mem2",  OP_LOAD, 1, 0, E_MEM_LD);
        step("ld_wb",    OP_LOAD, 1, 0, e_wb(2'b01, 2'b00));

        // STORE retires from MEM
        step("st_fetch", OP_STORE, 1, 0, E_F_RDY);
        step("st_dec",   OP_STORE, 1, 0, E_DEC);
        step("st_exec",  OP_STORE, 1, 0, E_EXEC);
        step("st_mem",   OP_STORE, 1, 0, E_ST_RET);

        // Branches taken / not taken
        step("bt_fetch", OP_BRANCH, 1, 0, E_F_RDY);
        step("bt_dec",   OP_BRANCH, 1, 0, E_DEC);
        step("bt_exec",  OP_BRANCH, 1, 1, e_br(2'b01));
        step("bn_fetch", OP_BRANCH, 1, 0, E_F_RDY);
        step("bn_dec",   OP_BRANCH, 1, 0, E_DEC);
        step("bn_exec",  OP_BRANCH, 1, 0, e_br(2'b00));

        // Jumps and upper-immediate classes
        step("jal_fetch",  OP_JAL, 1, 0, E_F_RDY);
        step("jal_dec",    OP_JAL, 1, 0, E_DEC);
        step("jal_exec",   OP_JAL, 1, 0, E_EXEC);
        step("jal_wb",     OP_JAL, 1, 0, e_wb(2'b10, 2'b10));
        step("jalr_fetch", OP_JALR, 1, 0, E_F_RDY);
        step("jalr_dec",   OP_JALR, 1, 0, E_DEC);
        step("jalr_exec",  OP_JALR, 1, 0, E_EXEC);
        step("jalr_wb",    OP_JALR, 1, 0, e_wb(2'b10, 2'b11));
        step("lui_fetch",  OP_LUI, 1, 0, E_F_RDY);
        step("lui_dec",    OP_LUI, 1, 0, E_DEC);
        step("lui_exec",   OP_BAD, 1, 0, E_EXEC);
        step("lui_wb",     OP_JAL, 1, 0, e_wb(2'b11, 2'b00));
        step("aui_fetch",  OP_AUIPC, 1, 0, E_F_RDY);
        step("aui_dec",    OP_AUIPC, 1, 0, E_DEC);
        step("aui_exec",   OP_AUIPC, 1, 0, E_EXEC);
        step("aui_wb",     OP_AUIPC, 1, 0, e_wb(2'b00, 2'b00));

        // Ready on the last allowed cycle is accepted
        step("late_w0",  OP_R, 0, 0, E_F_WAIT);
        step("late_w1",  OP_R, 0, 0, E_F_WAIT);
        step("late_w2",  OP_R, 0, 0, E_F_WAIT);
        step("late_rdy", OP_R, 1, 0, E_F_RDY);
        step("late_dec", OP_R, 1, 0, E_DEC);
        step("late_ex",  OP_R, 1, 0, E_EXEC);
        step("late_wb",  OP_R, 1, 0, e_wb(2'b00, 2'b00));

        // Fetch timeout after exactly four request cycles
        step("to_w0",   OP_R, 0, 0, E_F_WAIT);
        step("to_w1",   OP_R, 0, 0, E_F_WAIT);
        step("to_w2",   OP_R, 0, 0, E_F_WAIT);
        step("to_w3",   OP_R, 0, 0, E_F_WAIT);
        step("to_trap", OP_R, 1, 0, E_TRAP);
        step("to_stick", OP_LOAD, 0, 1, E_TRAP);
        reset = 1'b1;
        #1;
        check_val("to_reset", obs(), E_ZERO);
        @(negedge clk);
        reset = 1'b0;

        // Illegal opcode
        step("ill_fetch", OP_BAD, 1, 0, E_F_RDY);
        step("ill_dec",   OP_BAD, 1, 0, E_DEC);
        step("ill_trap",  OP_R, 1, 0, E_TRAP);
        step("ill_stick", OP_STORE, 0, 1, E_TRAP);
        step("ill_stick2", OP_R, 1, 0, E_TRAP);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        step("ill_after", OP_R, 0, 0, E_F_WAIT);

        // Asynchronous reset in the middle of a STORE memory phase
        step("ar_fetch", OP_STORE, 1, 0, E_F_RDY);
        step("ar_dec",   OP_STORE, 1, 0, E_DEC);
        step("ar_exec",  OP_STORE, 1, 0, E_EXEC);
        sif.mem_ready = 1'b0;
        #1;
        check_val("ar_mem", obs(), E_ST_WAIT);
        #2;
        reset = 1'b1;
        #1;
        check_val("ar_async", obs(), E_ZERO);
        @(negedge clk);
        reset = 1'b0;
        step("ar_refetch", OP_STORE, 0, 0, E_F_WAIT);
        step("ar_rdy",     OP_STORE, 1, 0, E_F_RDY);
        step("ar_dec2",    OP_STORE, 1, 0, E_DEC);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/core_sequencer.md
Name: core_sequencer

Overview:
- Multi-cycle instruction sequencer for the RV32I microcontroller core.
- Steps each instruction through FETCH, DECODE, EXEC, MEM and WB. Drives the shared memory-port handshake, IR/PC load enables, writeback select and register-file write enable.
- Sits beside the combinational ALU-control decoder: the decoder supplies ALU operation codes, and this block supplies the timing of when results are captured.
- Bus timeouts and illegal opcodes go to a sticky TRAP state.

Parameters:
- TIMEOUT, 16, maximum number of cycles mem_req is held per access before TRAP. 0 disables the timeout. The counter width is $clog2(TIMEOUT+1).

Ports:
- clk  in  1  core clock, rising edge
- reset  in  1  asynchronous, active-high reset
- opcode  in  7  instr[6:0] from IR; valid from DECODE until the next FETCH
- mem_ready  in  1  memory completes the current access this cycle
- branch_taken  in  1  branch comparator result; valid in EXEC
- mem_req  out  1  memory access request
- mem_we  out  1  write strobe; qualified by mem_req
- addr_sel  out  1  memory address source: 0 = PC, 1 = ALU result
- ir_load  out  1  capture mem read data into IR
- pc_en  out  1  update PC
- pc_sel  out  2  PC source: 00 = PC+4, 01 = branch target, 10 = JAL target, 11 = JALR target
- reg_we  out  1  register-file write enable
- wb_sel  out  2  writeback source: 00 = ALU, 01 = mem data, 10 = PC+4, 11 = U-immediate
- instr_retired  out  1  one-cycle pulse when an instruction completes
- trap  out  1  sticky fault flag
- state  out  3  current state: FETCH = 0, DECODE = 1, EXEC = 2, MEM = 3, WB = 4, TRAP = 5

Behaviour:
- Reset (asynchronous): state = FETCH, wait counter = 0, latched class = 0, trap = 0. All outputs are forced to 0 while reset is high. The first mem_req is asserted in the first cycle after reset deasserts.
- Outputs are combinational from the current state, the latched class and the inputs. All other outputs are 0 unless listed below.
- Opcode classes:
  - R = 0110011
  - IALU = 0010011
  - LOAD = 0000011
  - STORE = 0100011
  - BRANCH = 1100011
  - JAL = 1101111
  - JALR = 1100111
  - LUI = 0110111
  - AUIPC = 0010111
  - Any other opcode is ILLEGAL.
- FETCH: mem_req = 1, addr_sel = 0.
  - mem_ready = 1: ir_load = 1 in the same cycle; next state DECODE.
- DECODE: classify opcode and latch the class into an internal register; later states use only the latched class.
  - ILLEGAL: next state TRAP.
  - Otherwise: next state EXEC.
- EXEC (1 cycle):
  - LOAD or STORE: next state MEM.
  - BRANCH: pc_en = 1, pc_sel = 01 if branch_taken else 00, instr_retired = 1; next state FETCH.
  - Other classes: next state WB.
- MEM: mem_req = 1, addr_sel = 1, mem_we = 1 only for STORE.
  - Ready, STORE: pc_en = 1, pc_sel = 00, instr_retired = 1; next state FETCH.
  - Ready, LOAD: next state WB.
- WB: reg_we = 1, pc_en = 1, instr_retired = 1; next state FETCH.
  - R, IALU, AUIPC: wb_sel = 00, pc_sel = 00.
  - LOAD: wb_sel = 01, pc_sel = 00.
  - JAL: wb_sel = 10, pc_sel = 10.
  - JALR: wb_sel = 10, pc_sel = 11.
  - LUI: wb_sel = 11, pc_sel = 00.
- Wait counter:
  - Cleared on entry to FETCH or MEM.
  - Increments each FETCH/MEM cycle in which mem_ready = 0.
  - With TIMEOUT > 0: if the counter equals TIMEOUT-1 and mem_ready = 0, the next state is TRAP. mem_req is therefore held for at most TIMEOUT cycles, and ready arriving in cycle TIMEOUT is still accepted.
- TRAP: trap = 1; all other outputs 0. Sticky: the block stays in TRAP until reset. Inputs are ignored.
- mem_ready outside FETCH/MEM is ignored.
- mem_req never drops before mem_ready or timeout.
- Zero-wait latency in cycles: ALU/LUI/AUIPC/JAL/JALR = 4, LOAD = 5, STORE = 4, BRANCH = 3. Each memory wait cycle adds 1.
- Reset asserted mid-instruction: immediate return to FETCH; no pc_en, reg_we or instr_retired is emitted for the aborted instruction.
- opcode changing after DECODE has no effect until the next DECODE.

Test Plan:
- Reset release, opcode = 0110011, mem_ready held 1 -> states 0,1,2,4. ir_load in cycle 0. In cycle 3: reg_we = 1, wb_sel = 00, pc_en = 1, pc_sel = 00, instr_retired = 1. Repeat period is 4 cycles.
- LOAD (0000011) with mem_ready low for 2 MEM cycles -> MEM lasts 3 cycles with addr_sel = 1, mem_we = 0, then WB with wb_sel = 01. Total 7 cycles. STORE (0100011) -> mem_we = 1 in MEM; retires on ready with no WB state and reg_we never asserted.
- BRANCH with branch_taken = 1, then = 0 -> EXEC gives pc_sel = 01, then 00; retires in 3 cycles, reg_we = 0. JAL/JALR -> WB gives wb_sel = 10 with pc_sel = 10 or 11. LUI -> wb_sel = 11.
- TIMEOUT = 4, mem_ready stuck 0 in FETCH -> mem_req high exactly 4 cycles, then state = 5, trap = 1, all other outputs 0. Separately, ready on the 4th cycle -> DECODE, no trap.
- opcode = 1111111 -> DECODE goes to TRAP with trap = 1. Toggling mem_ready and opcode has no effect until reset; after reset, state = 0 and trap = 0.
- Reset asserted asynchronously in MEM of a STORE -> outputs 0 immediately, no instr_retired. After release, state = FETCH with mem_req = 1 and addr_sel = 0.
